// File: rtl/core_seq_pkg.sv
// Shared types and sizing for the core sequencer and its branch target table.
package core_seq_pkg;

  localparam int unsigned PC_W_DEF    = 10;
  localparam int unsigned TGT_ENTRIES = 64;
  localparam int unsigned TGT_SEL_W   = $clog2(TGT_ENTRIES);
  localparam int unsigned CNT_W       = 32;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_STALL = 2'd2,
    ST_DONE  = 2'd3
  } seq_state_e;

endpackage

// File: rtl/core_seq_branch_lut.sv
// Branch target table: decoder selector -> absolute PC. Contents are program
// specific and regenerated by the assembler; unlisted selectors fall back to START_PC.
module branch_target_lut
  import core_seq_pkg::*;
#(
  parameter int unsigned PC_W     = PC_W_DEF,
  parameter int unsigned START_PC = 0
) (
  input  logic [TGT_SEL_W-1:0] sel_i,
  output logic [PC_W-1:0]      target_o
);

  always_comb begin
    target_o = PC_W'(START_PC);
    case (sel_i)
      TGT_SEL_W'(1):  target_o = PC_W'(1022);
      TGT_SEL_W'(2):  target_o = PC_W'(100);
      TGT_SEL_W'(5):  target_o = PC_W'(40);
      TGT_SEL_W'(10): target_o = PC_W'(7);
      TGT_SEL_W'(33): target_o = PC_W'(513);
      TGT_SEL_W'(63): target_o = PC_W'(500);
      default:        target_o = PC_W'(START_PC);
    endcase
  end

endmodule

// File: rtl/core_sequencer.sv
// Program counter, Start/Done handshake, branch redirect and load stall sequencing
// for the single-issue core; gates architectural write enables outside RUN/STALL.
module core_sequencer
  import core_seq_pkg::*;
#(
  parameter int unsigned PC_W       = PC_W_DEF,
  parameter int unsigned START_PC   = 0,
  parameter bit          LOAD_STALL = 1'b1
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 start_i,
  input  logic                 halt_i,
  input  logic                 branch_en_i,
  input  logic [TGT_SEL_W-1:0] targ_sel_i,
  input  logic                 mem_read_i,
  input  logic                 mem_write_i,
  input  logic                 reg_write_i,
  output logic [PC_W-1:0]      pc_o,
  output logic                 instr_valid_o,
  output logic                 mem_read_en_o,
  output logic                 mem_write_en_o,
  output logic                 reg_write_en_o,
  output logic                 done_o,
  output logic [CNT_W-1:0]     cycle_count_o
);

  seq_state_e       state_q, state_d;
  logic [PC_W-1:0]  pc_q, pc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             done_q, done_d;
  logic             armed_q, armed_d;
  logic [PC_W-1:0]  target;
  logic             run_c, stall_c, load_stall_c;

  branch_target_lut #(
    .PC_W     (PC_W),
    .START_PC (START_PC)
  ) u_lut (
    .sel_i    (targ_sel_i),
    .target_o (target)
  );

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
      pc_q    <= PC_W'(START_PC);
      cnt_q   <= '0;
      done_q  <= 1'b0;
      armed_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
      armed_q <= armed_d;
    end
  end

  // Start re-arms from any state; otherwise the per-state sequencing applies.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    cnt_d   = cnt_q;
    done_d  = done_q;
    armed_d = armed_q;
    if (start_i) begin
      state_d = ST_IDLE;
      pc_d    = PC_W'(START_PC);
      cnt_d   = '0;
      done_d  = 1'b0;
      armed_d = 1'b1;
    end else begin
      if ((state_q == ST_RUN || state_q == ST_STALL) && cnt_q != '1) begin
        cnt_d = cnt_q + CNT_W'(1);
      end
      case (state_q)
        ST_IDLE: begin
          if (armed_q) begin
            state_d = ST_RUN;
            armed_d = 1'b0;
          end
        end
        ST_RUN: begin
          if (halt_i) begin
            state_d = ST_DONE;
            done_d  = 1'b1;
          end else if (load_stall_c) begin
            state_d = ST_STALL;
          end else if (branch_en_i) begin
            pc_d = target;
          end else begin
            pc_d = pc_q + PC_W'(1);
          end
        end
        ST_STALL: begin
          pc_d    = pc_q + PC_W'(1);
          state_d = ST_RUN;
        end
        ST_DONE: done_d = 1'b1;
        default: state_d = ST_IDLE;
      endcase
    end
  end

  assign run_c        = (state_q == ST_RUN);
  assign stall_c      = (state_q == ST_STALL);
  assign load_stall_c = mem_read_i & LOAD_STALL;

  // A stalled load writes its register on the second (STALL) cycle only.
  assign instr_valid_o  = run_c;
  assign mem_write_en_o = mem_write_i & run_c & ~halt_i;
  assign mem_read_en_o  = mem_read_i & (run_c | stall_c);
  assign reg_write_en_o = reg_write_i & ~halt_i & ((run_c & ~load_stall_c) | stall_c);
  assign pc_o           = pc_q;
  assign done_o         = done_q;
  assign cycle_count_o  = cnt_q;

endmodule
